lpc_frame_ctrl: RTL and testbench

// - Parametrised frame controller for the LPC encoder. Counts valid input samples, fires the solver reset/start per frame, captures the solved coefficient vector into a shadow bank, and serves the bank plus status over Avalon-MM.
// - Sits between the correlation/LDR datapath and the CPU. Unlike the previous single-register rate counter, it adds per-frame FSM tracking, overrun detection, enable/soft-restart and coefficient readback.

---
 rtl/lpc_frame_ctrl.sv | 105 ++++++++++
 tb/tb_lpc_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_frame_ctrl.sv
// lpc_frame_ctrl: per-frame sample counter, solver reset/start sequencing and coefficient bank over Avalon-MM.
// Define LPC_FRAME_IRQ_EN to add the irq output and the CTRL interrupt-enable bits.
module lpc_frame_ctrl #(
  parameter int ORDER    = 10,
  parameter int DW       = 16,
  parameter int CW       = 16,
  parameter int ADDR_W   = 16,
  parameter int DEF_RATE = 160
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    v,
  output logic                    solver_rst,
  output logic                    solver_start,
  input  logic                    solver_done,
  input  logic [(ORDER+1)*DW-1:0] solver_coef,
  output logic [(ORDER+1)*DW-1:0] coef,
  output logic                    coef_valid,
  output logic                    busy,
`ifdef LPC_FRAME_IRQ_EN
  output logic                    irq,
`endif
  input  logic [ADDR_W-1:0]       address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DW-1:0]           writedata,
  output logic [DW-1:0]           readdata
);
  typedef enum logic {S_COLLECT, S_SOLVE} state_t;
  localparam int MW = (CW > DW) ? CW : DW;
  localparam logic [DW-1:0] BAD = DW'(32'h0BAD);
  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_rate, r_fcnt, w_rdata, w_ctrl;
  logic          r_en, r_ovr, r_frdy;
  logic          w_wr_rate, w_wr_ctrl, w_wr_stat, w_rd_stat;
  logic          w_restart, w_bnd, w_cap, w_ovr_ev;
  assign w_wr_rate = write && address == ADDR_W'(0);
  assign w_wr_ctrl = write && address == ADDR_W'(1);
  assign w_wr_stat = write && address == ADDR_W'(2);
  assign w_rd_stat = read && address == ADDR_W'(2);
  assign w_restart = w_wr_ctrl && writedata[1];
  // >= so that a RATE lowered below the running count closes the frame on the next sample
  assign w_bnd     = r_en && v && !w_restart && (MW'(r_count) >= MW'(r_rate) - MW'(1));
  assign w_cap     = r_en && r_state == S_SOLVE && solver_done;
  assign w_ovr_ev  = w_bnd && r_state == S_SOLVE && !solver_done;
  assign busy      = r_state == S_SOLVE;
`ifdef LPC_FRAME_IRQ_EN
  logic r_fie, r_oie;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fie <= 1'b0;
      r_oie <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_fie <= writedata[2];
        r_oie <= writedata[3];
      end
      irq <= (r_frdy & r_fie) | (r_ovr & r_oie);
    end
  end
  assign w_ctrl = DW'({r_oie, r_fie, 1'b0, r_en});
`else
  assign w_ctrl = DW'(r_en);
`endif
  always_comb begin
    w_rdata = BAD;
    for (int k = 0; k <= ORDER; k++)
      if (address == ADDR_W'(16 + k)) w_rdata = coef[k*DW +: DW];
    if (address == ADDR_W'(0)) w_rdata = r_rate;
    if (address == ADDR_W'(1)) w_rdata = w_ctrl;
    if (address == ADDR_W'(2)) w_rdata = DW'({r_frdy, r_ovr, busy});
    if (address == ADDR_W'(3)) w_rdata = r_fcnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_COLLECT;
      r_count      <= '0;
      r_rate       <= DW'(DEF_RATE);
      r_en         <= 1'b1;
      r_ovr        <= 1'b0;
      r_frdy       <= 1'b0;
      r_fcnt       <= '0;
      solver_rst   <= 1'b0;
      solver_start <= 1'b0;
      coef         <= '0;
      coef_valid   <= 1'b0;
      readdata     <= '0;
    end else begin
      r_count      <= (!r_en || w_restart || w_bnd) ? '0 : v ? r_count + CW'(1) : r_count;
      r_state      <= (!r_en || w_restart) ? S_COLLECT : w_bnd ? S_SOLVE : w_cap ? S_COLLECT : r_state;
      solver_rst   <= w_bnd;
      solver_start <= solver_rst && r_en && !w_restart;
      coef_valid   <= w_cap;
      if (w_cap) coef <= solver_coef;
      r_fcnt       <= r_fcnt + DW'(w_cap);
      r_ovr        <= w_ovr_ev | (r_ovr & !(w_wr_stat & writedata[1]));
      r_frdy       <= w_cap | (r_frdy & !(w_wr_stat & writedata[2]) & !w_rd_stat);
      if (w_wr_rate && writedata >= DW'(ORDER + 1)) r_rate <= writedata;
      if (w_wr_ctrl) r_en <= writedata[0];
      readdata     <= read ? w_rdata : '0;
    end
  end
endmodule

// File: tb/tb_lpc_frame_ctrl.sv
// tb_lpc_frame_ctrl: directed plus randomized bench against a frame-level reference model.
module tb_lpc_frame_ctrl;
  localparam int ORDER = 10, DW = 16, CW = 16, ADDR_W = 16, NC = ORDER + 1;
  logic clk = 0, rst = 1, v = 0, solver_done = 0, read = 0, write = 0;
  logic solver_rst, solver_start, coef_valid, busy;
  logic [NC*DW-1:0] solver_coef = '0, coef;
  logic [ADDR_W-1:0] address = '0;
  logic [DW-1:0] writedata = '0, readdata;
`ifdef LPC_FRAME_IRQ_EN
  logic irq;
`endif
  int tests = 0, fails = 0, cyc_n = 0;
  int m_rate, m_cnt, m_start_cycle;
  logic m_en, m_solving, m_ovr, m_frdy, m_fie, m_oie, m_irq;
  logic [DW-1:0] m_fcnt;
  logic [DW-1:0] m_coef [NC];
  logic e_rst, e_start, e_valid;
  logic [DW-1:0] e_rd;

  lpc_frame_ctrl #(.ORDER(ORDER), .DW(DW), .CW(CW), .ADDR_W(ADDR_W), .DEF_RATE(160)) dut (
    .clk(clk), .rst(rst), .v(v), .solver_rst(solver_rst), .solver_start(solver_start),
    .solver_done(solver_done), .solver_coef(solver_coef), .coef(coef), .coef_valid(coef_valid),
    .busy(busy),
`ifdef LPC_FRAME_IRQ_EN
    .irq(irq),
`endif
    .address(address), .read(read), .write(write), .writedata(writedata), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: samples-in-frame reaching RATE closes a frame; pulses are scheduled by cycle number.
  task automatic model_step();
    logic restart, bnd, cap, sclr1, sclr2;
    logic [DW-1:0] rv, ctrl_v;
    int a;
    if (rst) begin
      m_rate = 160; m_cnt = 0; m_start_cycle = -1; m_en = 1; m_solving = 0;
      m_ovr = 0; m_frdy = 0; m_fie = 0; m_oie = 0; m_irq = 0; m_fcnt = 0;
      for (int k = 0; k < NC; k++) m_coef[k] = '0;
      e_rst = 0; e_start = 0; e_valid = 0; e_rd = '0;
      return;
    end
    a = int'(address);
    ctrl_v = {12'b0, m_oie, m_fie, 1'b0, m_en};
    rv = (a == 0) ? DW'(m_rate) : (a == 1) ? ctrl_v : (a == 2) ? {13'b0, m_frdy, m_ovr, m_solving} :
         (a == 3) ? m_fcnt : (a >= 16 && a < 16 + NC) ? m_coef[a-16] : 16'h0BAD;
    restart = write && a == 1 && writedata[1];
    bnd = m_en && v && !restart && (m_cnt + 1 >= m_rate);
    cap = m_en && m_solving && solver_done;
    sclr1 = write && a == 2 && writedata[1];
    sclr2 = write && a == 2 && writedata[2];
    e_rst = bnd;
    e_start = m_en && !restart && (m_start_cycle == cyc_n);
    e_valid = cap;
    e_rd = read ? rv : '0;
    m_irq = (m_frdy && m_fie) || (m_ovr && m_oie);
    if (cap) for (int k = 0; k < NC; k++) m_coef[k] = solver_coef[k*DW +: DW];
    m_ovr = (bnd && m_solving && !solver_done) || (m_ovr && !sclr1);
    m_frdy = cap || (m_frdy && !sclr2 && !(read && a == 2));
    m_fcnt = m_fcnt + DW'(cap);
    if (bnd) m_start_cycle = cyc_n + 1;
    if (!m_en || restart) begin
      m_cnt = 0; m_solving = 0;
    end else begin
      m_cnt = bnd ? 0 : m_cnt + int'(v);
      m_solving = bnd ? 1'b1 : cap ? 1'b0 : m_solving;
    end
    if (write && a == 0 && int'(writedata) >= NC) m_rate = int'(writedata);
    if (write && a == 1) begin
      m_en = writedata[0];
`ifdef LPC_FRAME_IRQ_EN
      m_fie = writedata[2];
      m_oie = writedata[3];
`endif
    end
  endtask

  task automatic cyc();
    logic [NC*DW-1:0] ec;
    @(posedge clk);
    #1;
    model_step();
    for (int k = 0; k < NC; k++) ec[k*DW +: DW] = m_coef[k];
    chk("solver_rst", solver_rst, e_rst);
    chk("solver_start", solver_start, e_start);
    chk("busy", busy, m_solving);
    chk("coef_valid", coef_valid, e_valid);
    chk("coef", coef, ec);
    chk("readdata", readdata, e_rd);
`ifdef LPC_FRAME_IRQ_EN
    chk("irq", irq, m_irq);
`endif
    cyc_n++;
  endtask

  task automatic pv(int n);
    v = 1;
    repeat (n) cyc();
    v = 0;
  endtask

  task automatic wr(int a, int d);
    address = ADDR_W'(a); writedata = DW'(d); write = 1;
    cyc();
    write = 0;
  endtask

  task automatic rd(int a);
    address = ADDR_W'(a); read = 1;
    cyc();
    read = 0;
  endtask

  initial begin
    int np, r;
    repeat (3) cyc();
    rst = 0;
    chk("rst_coef", coef, 0);
    chk("rst_busy", busy, 0);
    cyc();
    pv(159);
    chk("no_bnd_159", solver_rst, 0);
    pv(1);
    chk("bnd_rst", solver_rst, 1);
    chk("bnd_busy", busy, 1);
    cyc();
    chk("start", solver_start, 1);
    solver_coef = '0;
    solver_coef[15:0] = 16'h1000;
    solver_coef[31:16] = 16'hF000;
    solver_done = 1;
    cyc();
    solver_done = 0;
    chk("a0", coef[15:0], 16'h1000);
    chk("a1", coef[31:16], 16'hF000);
    chk("valid", coef_valid, 1);
    cyc();
    chk("valid_once", coef_valid, 0);
    rd(3);
    chk("frame_cnt", readdata, 1);
    rd(2);
    chk("status_frdy", readdata, 4);
    wr(0, 5);
    rd(0);
    chk("rate_keep", readdata, 160);
    wr(0, 20);
    rd(0);
    chk("rate20", readdata, 20);
    cyc();
    chk("rd_idle", readdata, 0);
    pv(40);
    cyc();
    rd(2);
    chk("status_ovr", readdata, 3);
    chk("ovr_coef", coef[15:0], 16'h1000);
    wr(2, 2);
    rd(2);
    chk("status_clr", readdata, 1);
    pv(19);
    solver_coef[15:0] = 16'h2222;
    v = 1; solver_done = 1;
    cyc();
    v = 0; solver_done = 0;
    chk("co_valid", coef_valid, 1);
    chk("co_rst", solver_rst, 1);
    chk("co_a0", coef[15:0], 16'h2222);
    cyc();
    chk("co_start", solver_start, 1);
    rd(2);
    chk("co_status", readdata, 5);
    pv(7);
    wr(1, 0);
    np = 0;
    v = 1;
    repeat (100) begin
      cyc();
      np = np + int'(solver_rst) + int'(solver_start);
    end
    v = 0;
    chk("dis_pulses", np, 0);
    chk("dis_busy", busy, 0);
    wr(1, 1);
    pv(19);
    chk("reen_19", solver_rst, 0);
    pv(1);
    chk("reen_20", solver_rst, 1);
    cyc();
    rd(27);
    chk("bad_addr", readdata, 16'h0BAD);
    cyc();
    chk("rd_low", readdata, 0);
`ifdef LPC_FRAME_IRQ_EN
    wr(1, 5);
    solver_done = 1;
    cyc();
    solver_done = 0;
    cyc();
    chk("irq_on", irq, 1);
    rd(2);
    cyc();
    chk("irq_off", irq, 0);
`endif
    pv(10);
    wr(1, 3);
    pv(19);
    chk("rs_19", solver_rst, 0);
    pv(1);
    chk("rs_20", solver_rst, 1);
    cyc();
    pv(19);
    address = ADDR_W'(1); writedata = 16'd3; write = 1; v = 1;
    cyc();
    write = 0; v = 0;
    chk("rs_pri", solver_rst, 0);
    chk("rs_pri_busy", busy, 0);
    cyc();
    chk("rs_nostart", solver_start, 0);
    pv(20);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_nostart", solver_start, 0);
    chk("rst_busy2", busy, 0);
    cyc();
    chk("rst_nostart2", solver_start, 0);
    rd(0);
    chk("rst_rate", readdata, 160);
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(99) < 70);
      solver_done = ($urandom_range(99) < 8);
      for (int k = 0; k < NC; k++) solver_coef[k*DW +: DW] = DW'($urandom);
      read = ($urandom_range(99) < 30);
      write = ($urandom_range(99) < 6);
      rst = ($urandom_range(999) < 3);
      r = int'($urandom_range(9));
      address = (r < 5) ? ADDR_W'(r) : ADDR_W'(14 + $urandom_range(14));
      writedata = (address == 0) ? DW'($urandom_range(40)) :
                  (address == 1) ? DW'({$urandom_range(3), ($urandom_range(9) == 0), ($urandom_range(9) != 0)}) :
                  DW'($urandom);
      cyc();
    end
    v = 0; solver_done = 0; read = 0; write = 0; rst = 0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
